// File: rtl/inv_matrix_stream_io_pkg.sv
// Shared constants, FSM state types and element slicing helpers for the
// 4x4 matrix inverter stream front/back end.
package inv_matrix_stream_io_pkg;
   localparam int ELEM_W = 32;
   localparam int N_ELEM = 16;
   localparam int IDX_W  = 4;
   localparam int FLAT_W = ELEM_W * N_ELEM;

   typedef logic [IDX_W-1:0] idx_t;
   localparam idx_t LAST_IDX = idx_t'(N_ELEM - 1);

   typedef enum logic [1:0] {
      LD_LOAD    = 2'd0,
      LD_SETTLE  = 2'd1,
      LD_CAPWAIT = 2'd2
   } ld_state_t;

   typedef enum logic {
      SND_IDLE = 1'b0,
      SND_SEND = 1'b1
   } snd_state_t;

   function automatic logic [ELEM_W-1:0] get_elem(input logic [FLAT_W-1:0] flat, input idx_t idx);
      return flat[int'(idx)*ELEM_W +: ELEM_W];
   endfunction

   function automatic logic [FLAT_W-1:0] put_elem(input logic [FLAT_W-1:0] flat, input idx_t idx,
                                                  input logic [ELEM_W-1:0] val);
      logic [FLAT_W-1:0] res;
      res = flat;
      res[int'(idx)*ELEM_W +: ELEM_W] = val;
      return res;
   endfunction
endpackage

// File: rtl/inv_matrix_stream_io_serializer.sv
// Result buffer and send FSM: captures the inverter outputs in one shot and
// streams them out row-major over a registered valid/ready interface.
module matrix_result_serializer
   import inv_matrix_stream_io_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [FLAT_W-1:0] cap_data,
   output logic              cap_ok,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic              out_last
);
   snd_state_t        state;
   idx_t              snd_idx;
   idx_t              next_idx;
   logic [FLAT_W-1:0] res_buf;
   logic              hs;
   logic              final_hs;

   assign hs       = out_valid & out_ready;
   assign final_hs = hs & (snd_idx == LAST_IDX);
   assign next_idx = snd_idx + idx_t'(1);
   // A new capture may land on the very cycle the last element leaves.
   assign cap_ok   = (state == SND_IDLE) | final_hs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SND_IDLE;
         snd_idx   <= '0;
         res_buf   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (capture) begin
         res_buf   <= cap_data;
         state     <= SND_SEND;
         snd_idx   <= '0;
         out_valid <= 1'b1;
         out_data  <= get_elem(cap_data, idx_t'(0));
         out_last  <= 1'b0;
      end else if (hs) begin
         if (final_hs) begin
            state     <= SND_IDLE;
            snd_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            snd_idx  <= next_idx;
            out_data <= get_elem(res_buf, next_idx);
            out_last <= (next_idx == LAST_IDX);
         end
      end
   end
endmodule

// File: rtl/inv_matrix_stream_io.sv
// Serial-to-parallel loader for the 4x4 inverter: collects 16 elements, holds
// them for a settle time, then hands the inverter outputs to the serializer.
module inv_matrix_stream_io
   import inv_matrix_stream_io_pkg::*;
#(
   parameter int SETTLE_CYC = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ELEM_W-1:0] in_data,
   input  logic              in_last,
   output logic [FLAT_W-1:0] mat_flat,
   input  logic [FLAT_W-1:0] inv_flat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic              out_last,
   output logic              err_frame
);
   localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYC - 1);

   ld_state_t  ld_state;
   idx_t       ld_idx;
   logic [3:0] settle_cnt;
   logic       in_hs;
   logic       cap_ok;
   logic       capture;

   assign in_ready = ~rst & (ld_state == LD_LOAD);
   assign in_hs    = in_valid & in_ready;
   assign capture  = (ld_state == LD_CAPWAIT) & cap_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_state   <= LD_LOAD;
         ld_idx     <= '0;
         settle_cnt <= '0;
         mat_flat   <= '0;
         err_frame  <= 1'b0;
      end else begin
         case (ld_state)
            LD_LOAD: begin
               if (in_hs) begin
                  mat_flat <= put_elem(mat_flat, ld_idx, in_data);
                  // Element count owns framing; in_last only raises the flag.
                  if (in_last != (ld_idx == LAST_IDX))
                     err_frame <= 1'b1;
                  if (ld_idx == LAST_IDX) begin
                     ld_idx     <= '0;
                     settle_cnt <= '0;
                     ld_state   <= LD_SETTLE;
                  end else begin
                     ld_idx <= ld_idx + idx_t'(1);
                  end
               end
            end
            LD_SETTLE: begin
               if (settle_cnt == SETTLE_END)
                  ld_state <= LD_CAPWAIT;
               else
                  settle_cnt <= settle_cnt + 4'd1;
            end
            LD_CAPWAIT: begin
               if (capture)
                  ld_state <= LD_LOAD;
            end
            default: ld_state <= LD_LOAD;
         endcase
      end
   end

   matrix_result_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .cap_data  (inv_flat),
      .cap_ok    (cap_ok),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );
endmodule

// File: tb/tb_inv_matrix_stream_io.sv
// Scoreboard bench: inverter stub adds 1 per element; each fully loaded matrix
// pushes its 16 expected outputs, a negedge monitor pops on every handshake.
module tb_inv_matrix_stream_io;
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_last;
   logic [31:0]  in_data;
   logic [511:0] mat_flat, inv_flat;
   logic         out_valid, out_ready, out_last;
   logic [31:0]  out_data;
   logic         err_frame;

   always #5 clk = ~clk;

   inv_matrix_stream_io #(.SETTLE_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .mat_flat(mat_flat), .inv_flat(inv_flat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .err_frame(err_frame)
   );

   for (genvar gi = 0; gi < 16; gi++) begin : g_stub
      assign inv_flat[gi*32 +: 32] = mat_flat[gi*32 +: 32] + 32'd1;
   end

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] cur[16];
   int          tests = 0;
   int          fails = 0;
   bit          rand_ready = 0;
   logic        ready_cmd = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // out_ready updates at posedge+2 so commands issued at posedge+1 never race it
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_last", out_last, e.last);
            end
         end
      end
   end

   // Entered and left at posedge+1. Pushes expectations only for a full matrix.
   task automatic load_matrix(input int n, input int gap_mode, input int bad_idx);
      int   w;
      exp_t e;
      for (int k = 0; k < n; k++) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = cur[k];
         in_last  = ((k == 15) != (k == bad_idx));
         w = 0;
         @(negedge clk);
         while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) begin
            timeout_fail("in_ready_wait");
            in_valid = 1'b0;
            in_last  = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
         if (k == bad_idx) check("err_frame_set", err_frame, 1'b1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (n == 16) begin
         for (int k = 0; k < 16; k++) begin
            e.data = cur[k] + 32'd1;
            e.last = (k == 15);
            sb.push_back(e);
         end
      end
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb.size() > 0 && w < 3000) begin
         @(posedge clk);
         w++;
      end
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [511:0] exp_flat;
      int           w;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_err_frame", err_frame, 1'b0);
      check("rst_mat_flat", mat_flat, 512'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // basic load and send
      ready_cmd = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 16; k++) cur[k] = 32'(k);
      load_matrix(16, 0, -1);
      check("in_ready_after_16", in_ready, 1'b0);
      wait_drain();
      check("err_frame_clean", err_frame, 1'b0);

      // output backpressure
      ready_cmd = 1'b0;
      @(posedge clk); #1;
      load_matrix(16, 0, -1);
      w = 0;
      do begin @(negedge clk); w++; end while (!out_valid && w < 100);
      if (!out_valid) timeout_fail("bp_out_valid");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_data", out_data, 32'h1);
      end
      ready_cmd = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!out_ready && w < 10);
      check("bp_rise_data", out_data, 32'h1);
      @(negedge clk);
      check("bp_advance_data", out_data, 32'h2);
      @(posedge clk); #1;
      wait_drain();

      // overlapped load with back-to-back output
      ready_cmd = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 16; k++) cur[k] = 32'(k);
      load_matrix(16, 0, -1);
      for (int k = 0; k < 16; k++) cur[k] = 32'h100 + 32'(k);
      fork
         begin
            load_matrix(16, 0, -1);
            for (int k = 0; k < 16; k++) exp_flat[k*32 +: 32] = cur[k];
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               check("settle_frozen", mat_flat, exp_flat);
            end
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         begin
            int wr;
            wr = 0;
            do begin @(negedge clk); wr++; end while (!out_valid && wr < 100);
            repeat (12) @(posedge clk);
            ready_cmd = 1'b1;
         end
         begin
            int wb;
            wb = 0;
            do begin
               @(negedge clk);
               wb++;
            end while (!(out_valid && out_ready && out_last && out_data == 32'h10) && wb < 300);
            if (wb >= 300) timeout_fail("b2b_wait");
            @(negedge clk);
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_data", out_data, 32'h101);
         end
      join
      wait_drain();

      // input gaps
      for (int k = 0; k < 16; k++) cur[k] = 32'h40 + 32'(k);
      load_matrix(16, 1, -1);
      check("gap_in_ready_low", in_ready, 1'b0);
      wait_drain();

      // randomized matrices, gaps and backpressure
      rand_ready = 1;
      for (int m = 0; m < 5; m++) begin
         for (int k = 0; k < 16; k++) cur[k] = $urandom;
         load_matrix(16, 2, -1);
      end
      wait_drain();
      rand_ready = 0;
      @(posedge clk); #1;

      // framing error
      check("err_frame_before", err_frame, 1'b0);
      for (int k = 0; k < 16; k++) cur[k] = 32'h30 + 32'(k);
      load_matrix(16, 0, 7);
      wait_drain();
      check("err_frame_sticky", err_frame, 1'b1);

      // mid-load reset
      for (int k = 0; k < 16; k++) cur[k] = 32'h20 + 32'(k);
      load_matrix(5, 0, -1);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_err_frame", err_frame, 1'b0);
      check("mrst_in_ready", in_ready, 1'b0);
      check("mrst_mat_flat", mat_flat, 512'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      load_matrix(16, 0, -1);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
